// File: rtl/lb_window2x2.sv
// 2x2 window generator: pops a raster pixel stream, keeps one previous line,
// and presents each complete 2x2 window over a valid/ready handshake.
module lb_window2x2 #(
  parameter int DW     = 16,
  parameter int LWIDTH = 8,
  parameter int LINES  = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] in_data,
  input  logic          in_empty,
  output logic          in_ren,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] out_tl,
  output logic [DW-1:0] out_tr,
  output logic [DW-1:0] out_bl,
  output logic [DW-1:0] out_br,
  output logic          out_last
);

  // state | meaning
  // FILL  | row 0 of a frame: line store is being primed, no windows
  // RUN   | rows 1..LINES-1: every pixel with col>0 completes a window

  localparam int CW = (LWIDTH > 1) ? $clog2(LWIDTH) : 1;
  localparam int RW = (LINES > 1) ? $clog2(LINES) : 1;
  localparam logic [CW-1:0] COL_MAX = CW'(LWIDTH - 1);
  localparam logic [RW-1:0] ROW_MAX = RW'(LINES - 1);

  typedef enum logic {FILL, RUN} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] col_q, col_d;
  logic [RW-1:0] row_q, row_d;
  logic [DW-1:0] top_prev_q, top_prev_d;
  logic [DW-1:0] cur_prev_q, cur_prev_d;
  logic          out_valid_q, out_valid_d;
  logic          out_last_q, out_last_d;
  logic [DW-1:0] out_tl_q, out_tl_d;
  logic [DW-1:0] out_tr_q, out_tr_d;
  logic [DW-1:0] out_bl_q, out_bl_d;
  logic [DW-1:0] out_br_q, out_br_d;
  logic [DW-1:0] linebuf_q [LWIDTH];
  logic [DW-1:0] linebuf_d [LWIDTH];
  logic [DW-1:0] top;
  logic          accept;

  // Gated by rst_n so nothing is popped while the block is held in reset.
  assign in_ren = rst_n && !in_empty && (!out_valid_q || out_ready);
  assign accept = in_ren;
  assign top    = linebuf_q[col_q];

  always_comb begin
    state_d    = state_q;
    col_d      = col_q;
    row_d      = row_q;
    top_prev_d = top_prev_q;
    cur_prev_d = cur_prev_q;
    out_valid_d = out_valid_q;
    out_last_d  = out_last_q;
    out_tl_d   = out_tl_q;
    out_tr_d   = out_tr_q;
    out_bl_d   = out_bl_q;
    out_br_d   = out_br_q;
    linebuf_d  = linebuf_q;

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
      out_last_d  = 1'b0;
    end

    if (accept) begin
      linebuf_d[col_q] = in_data;
      top_prev_d       = top;
      cur_prev_d       = in_data;

      // A new window overrides the retire above, giving back-to-back streaming.
      if (state_q == RUN && col_q != '0) begin
        out_tl_d    = top_prev_q;
        out_tr_d    = top;
        out_bl_d    = cur_prev_q;
        out_br_d    = in_data;
        out_valid_d = 1'b1;
        out_last_d  = (row_q == ROW_MAX) && (col_q == COL_MAX);
      end

      if (col_q == COL_MAX) begin
        col_d = '0;
        if (row_q == ROW_MAX) begin
          row_d   = '0;
          state_d = FILL;
        end else begin
          row_d   = row_q + 1'b1;
          state_d = RUN;
        end
      end else begin
        col_d = col_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= FILL;
      col_q       <= '0;
      row_q       <= '0;
      top_prev_q  <= '0;
      cur_prev_q  <= '0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_tl_q    <= '0;
      out_tr_q    <= '0;
      out_bl_q    <= '0;
      out_br_q    <= '0;
    end else begin
      state_q     <= state_d;
      col_q       <= col_d;
      row_q       <= row_d;
      top_prev_q  <= top_prev_d;
      cur_prev_q  <= cur_prev_d;
      out_valid_q <= out_valid_d;
      out_last_q  <= out_last_d;
      out_tl_q    <= out_tl_d;
      out_tr_q    <= out_tr_d;
      out_bl_q    <= out_bl_d;
      out_br_q    <= out_br_d;
    end
  end

  // Line store is not reset: row 0 rewrites every entry before it is read.
  always_ff @(posedge clk) begin
    linebuf_q <= linebuf_d;
  end

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_tl    = out_tl_q;
  assign out_tr    = out_tr_q;
  assign out_bl    = out_bl_q;
  assign out_br    = out_br_q;

endmodule

// File: tb/tb_lb_window2x2.sv
// Self-checking bench for lb_window2x2: scenario table plus scoreboard of
// expected windows derived from the pixel value formula base + row*16 + col.
module tb_lb_window2x2;

  localparam int DW     = 16;
  localparam int LWIDTH = 8;
  localparam int LINES  = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [DW-1:0] in_data;
  logic          in_empty;
  logic          in_ren;
  logic          out_valid;
  logic          out_ready;
  logic [DW-1:0] out_tl, out_tr, out_bl, out_br;
  logic          out_last;

  lb_window2x2 #(.DW(DW), .LWIDTH(LWIDTH), .LINES(LINES)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_data  (in_data),
    .in_empty (in_empty),
    .in_ren   (in_ren),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_tl   (out_tl),
    .out_tr   (out_tr),
    .out_bl   (out_bl),
    .out_br   (out_br),
    .out_last (out_last)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [DW-1:0] tl;
    logic [DW-1:0] tr;
    logic [DW-1:0] bl;
    logic [DW-1:0] br;
    logic          last;
  } win_t;

  typedef struct {
    int base;
    int frames;
    int empty_pct;
    int ready_pct;
    bit stall;
    int exp_windows;
    int exp_lasts;
  } scen_t;

  win_t  q[$];
  int    checks = 0;
  int    failures = 0;
  int    win_seen = 0;
  int    last_seen = 0;
  bit    prev_stall = 0;
  logic [95:0] snap;

  function automatic void chk(string nm, logic [95:0] act, logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h at %0t", nm, act, exp, $time);
    end
  endfunction

  function automatic logic [DW-1:0] pix(int base, int r, int c);
    return DW'(base + r * 16 + c);
  endfunction

  // Output monitor: pops the scoreboard on each handshake and checks hold under backpressure.
  always @(negedge clk) begin
    if (!rst_n) begin
      prev_stall = 0;
    end else begin
      if (prev_stall)
        chk("hold_stable", {out_valid, out_last, out_tl, out_tr, out_bl, out_br}, snap);
      if (out_valid && !out_ready)
        chk("ren_blocked", 96'(in_ren), 96'(0));
      if (out_valid && out_ready) begin
        if (q.size() == 0) begin
          chk("unexpected_window", 96'(1), 96'(0));
        end else begin
          win_t exp_w;
          exp_w = q.pop_front();
          chk("window", {out_tl, out_tr, out_bl, out_br, out_last}, exp_w);
        end
        win_seen++;
        if (out_last) last_seen++;
      end
      prev_stall = out_valid && !out_ready;
      snap = {out_valid, out_last, out_tl, out_tr, out_bl, out_br};
    end
  end

  task automatic run_frame(input int base, input int empty_pct, input int ready_pct,
                           input bit stall, input int npix);
    int idx = 0;
    int cyc = 0;
    int stall_cnt = 0;
    bit stall_done = 0;
    bit lat_pending = 0;
    int r, c;
    win_t w;
    while (idx < npix) begin
      @(posedge clk); #1;
      r = idx / LWIDTH;
      c = idx % LWIDTH;
      in_data  = pix(base, r, c);
      in_empty = ($urandom_range(99) < empty_pct);
      if (stall && !stall_done && idx >= 30 && out_valid) begin
        stall_cnt  = 5;
        stall_done = 1;
      end
      if (stall_cnt > 0) begin
        out_ready = 1'b0;
        stall_cnt--;
      end else begin
        out_ready = ($urandom_range(99) < ready_pct);
      end
      @(negedge clk);
      if (lat_pending) begin
        chk("first_latency", {out_valid, out_tl, out_tr, out_bl, out_br},
            {1'b1, pix(base, 0, 0), pix(base, 0, 1), pix(base, 1, 0), pix(base, 1, 1)});
        lat_pending = 0;
      end
      if (in_empty) chk("ren_vs_empty", 96'(in_ren), 96'(0));
      if (in_ren) begin
        if (r > 0 && c > 0) begin
          w.tl   = pix(base, r - 1, c - 1);
          w.tr   = pix(base, r - 1, c);
          w.bl   = pix(base, r, c - 1);
          w.br   = pix(base, r, c);
          w.last = (r == LINES - 1) && (c == LWIDTH - 1);
          q.push_back(w);
        end
        if (r == 1 && c == 1) lat_pending = 1;
        idx++;
      end
      cyc++;
      if (cyc > 3000) begin
        chk("frame_timeout", 96'(idx), 96'(npix));
        break;
      end
    end
  endtask

  task automatic drain();
    @(posedge clk); #1;
    in_empty  = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (q.size() == 0) break;
    end
    chk("drain_empty", 96'(q.size()), 96'(0));
  endtask

  scen_t tbl[5];

  initial begin
    tbl[0] = '{base: 'h000, frames: 1, empty_pct: 0,  ready_pct: 100, stall: 0, exp_windows: 49, exp_lasts: 1};
    tbl[1] = '{base: 'h000, frames: 1, empty_pct: 0,  ready_pct: 100, stall: 1, exp_windows: 49, exp_lasts: 1};
    tbl[2] = '{base: 'h000, frames: 1, empty_pct: 50, ready_pct: 100, stall: 0, exp_windows: 49, exp_lasts: 1};
    tbl[3] = '{base: 'h000, frames: 2, empty_pct: 0,  ready_pct: 100, stall: 0, exp_windows: 98, exp_lasts: 2};
    tbl[4] = '{base: 'h200, frames: 1, empty_pct: 30, ready_pct: 70,  stall: 0, exp_windows: 49, exp_lasts: 1};

    rst_n     = 1'b0;
    in_empty  = 1'b0;
    out_ready = 1'b1;
    in_data   = '0;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("rst_in_ren", 96'(in_ren), 96'(0));
      chk("rst_out_valid", 96'(out_valid), 96'(0));
    end
    chk("rst_out_data", {out_tl, out_tr, out_bl, out_br, out_last}, 96'(0));
    in_empty = 1'b1;
    #2 rst_n = 1'b1;

    for (int s = 0; s < 5; s++) begin
      win_seen  = 0;
      last_seen = 0;
      for (int f = 0; f < tbl[s].frames; f++)
        run_frame(tbl[s].base + f * 'h80, tbl[s].empty_pct, tbl[s].ready_pct,
                  tbl[s].stall, LWIDTH * LINES);
      drain();
      chk($sformatf("scen%0d_windows", s), 96'(win_seen), 96'(tbl[s].exp_windows));
      chk($sformatf("scen%0d_lasts", s), 96'(last_seen), 96'(tbl[s].exp_lasts));
    end

    // Mid-frame reset: hold a window under backpressure, then reset between edges.
    run_frame('h000, 0, 100, 0, 20);
    @(posedge clk); #1;
    in_empty  = 1'b1;
    out_ready = 1'b0;
    @(negedge clk);
    chk("pre_rst_window", {out_valid, out_br}, {1'b1, pix('h000, 2, 3)});
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("async_clear_valid", {out_valid, out_last}, 96'(0));
    chk("async_clear_data", {out_tl, out_tr, out_bl, out_br}, 96'(0));
    q.delete();
    @(negedge clk); #2;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    win_seen  = 0;
    last_seen = 0;
    run_frame('h300, 0, 100, 0, LWIDTH * LINES);
    drain();
    chk("post_rst_windows", 96'(win_seen), 96'(49));
    chk("post_rst_lasts", 96'(last_seen), 96'(1));

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired actual=running required=finished");
    $fatal(1);
  end

endmodule
